vote_tally_uart_tx: RTL
=======================

Name: vote_tally_uart_tx

Overview:
Reads the four 8-bit candidate tallies produced by the vote logger and transmits them off-chip as one framed UART (8N1) packet.
- Sits beside the mode controller on the results side of the voting machine.
- Accepts a start request only in result mode (mode=1).
- Snapshots the tallies, then serializes header, four counts and checksum on a single tx line.

Parameters:
CLKS_PER_BIT, 10, clock cycles per UART bit; legal range 2..65535; internal bit-timer is 16 bits.
HEADER, 8'hA5, first byte of every frame.

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high; clock clock
mode  input  1  0 = voting, 1 = result; start is honoured only when 1
start  input  1  level request; sampled every rising edge
cand1_count  input  8  tally for candidate 1
cand2_count  input  8  tally for candidate 2
cand3_count  input  8  tally for candidate 3
cand4_count  input  8  tally for candidate 4
tx  output  1  serial line, idles high
busy  output  1  high while a frame is in flight
done  output  1  one-cycle pulse when a frame completes

Behaviour:
Reset:
- At the reset edge: tx=1, busy=0, done=0, state=IDLE, all counters and the snapshot cleared.
- Reset mid-frame aborts the frame at that edge: tx=1 next cycle, no done pulse.

States:
- IDLE, START_BIT, DATA_BITS, STOP_BIT. A byte index 0..5 selects the byte being sent.

Accept:
- Occurs at edge E0 when state=IDLE, start=1 and mode=1.
- start while busy=1 or mode=0 is ignored. It is not queued.

At E0:
- Snapshot c1..c4 from cand1_count..cand4_count.
- Compute checksum = (c1+c2+c3+c4) mod 256 (8-bit wrap, carries discarded).
- Set byte index to 0, enter START_BIT, tx<=0, busy<=1.

Frame byte order: HEADER, c1, c2, c3, c4, checksum (6 bytes).

Each byte:
- Start bit (0).
- 8 data bits, LSB first.
- Stop bit (1).
- Each bit is held exactly CLKS_PER_BIT cycles; the timer counts 0..CLKS_PER_BIT-1.

Transitions:
- START_BIT to DATA_BITS after CLKS_PER_BIT cycles.
- DATA_BITS to STOP_BIT after 8 bits.
- At the end of STOP_BIT:
  - if byte index < 5: increment index and go to START_BIT (no idle gap between bytes);
  - else: go to IDLE.

Outputs:
- tx is registered with no glitches and changes only at bit boundaries.
- Total frame: 60*CLKS_PER_BIT cycles. tx returns high for idle at E0+60*CLKS_PER_BIT.
- At edge E0+60*CLKS_PER_BIT: busy<=0 and done<=1 for exactly one cycle.
- A start sampled during that done cycle (busy=0, mode=1) is accepted. The next frame's start bit begins the following cycle, so the idle high lasts 1 cycle minimum.

Boundary conditions:
- Tally inputs changing mid-frame do not affect the frame; only the snapshot is sent.
- mode dropping to 0 mid-frame does not abort the frame.
- Counts of 0 and 255 are sent unmodified.
- Checksum wraps modulo 256.

Test Plan:
- Nominal frame. CLKS_PER_BIT=10, mode=1, counts 3,2,1,0, start pulse 1 cycle. Required response:
  - decoded bytes A5,03,02,01,00,06;
  - busy high 600 cycles;
  - done single pulse at E0+600;
  - tx=1 afterward.
- Checksum wrap. Counts FF,FF,FF,FF. Required response: bytes A5,FF,FF,FF,FF,FC.
- Mode gating and busy gating.
  - start=1 with mode=0 held 50 cycles: tx stays 1, busy stays 0.
  - start re-pulsed at E0+100 during a frame: ignored, exactly 6 bytes sent, one done pulse.
- Snapshot. Counts 5,6,7,8 at accept, changed to 9,9,9,9 at E0+20. Required response: bytes A5,05,06,07,08,1A.
- Reset mid-frame. Reset at E0+250. Required response:
  - tx=1, busy=0 next cycle; no done pulse;
  - a new start after reset produces a complete correct frame.
- Back-to-back. start held high continuously. Required response:
  - second frame's start bit begins 1 cycle after done;
  - bit timing exact (10 cycles per bit ±0) across both frames.

Source files
------------

// File: rtl/vote_tally_uart_tx.sv
// Snapshots four 8-bit vote tallies and sends them as one 8N1 UART frame:
// HEADER, c1..c4, checksum, with no idle gap between the six bytes.
module vote_tally_uart_tx #(
    parameter int          CLKS_PER_BIT = 10,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       start,
    input  logic [7:0] cand1_count,
    input  logic [7:0] cand2_count,
    input  logic [7:0] cand3_count,
    input  logic [7:0] cand4_count,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] DATA_BITS = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  r_state;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [2:0]  r_byte_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_c1, r_c2, r_c3, r_c4, r_sum;
    logic        r_tx, r_busy, r_done;

    logic [7:0]  w_byte;
    logic        w_bit_end;

    assign w_bit_end = (r_timer == LAST_TICK);

    always_comb begin
        w_byte = HEADER;
        case (r_byte_idx)
            3'd1:    w_byte = r_c1;
            3'd2:    w_byte = r_c2;
            3'd3:    w_byte = r_c3;
            3'd4:    w_byte = r_c4;
            3'd5:    w_byte = r_sum;
            default: w_byte = HEADER;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_c1       <= '0;
            r_c2       <= '0;
            r_c3       <= '0;
            r_c4       <= '0;
            r_sum      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && mode) begin
                        r_c1       <= cand1_count;
                        r_c2       <= cand2_count;
                        r_c3       <= cand3_count;
                        r_c4       <= cand4_count;
                        r_sum      <= cand1_count + cand2_count + cand3_count + cand4_count;
                        r_byte_idx <= '0;
                        r_timer    <= '0;
                        r_state    <= START_BIT;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (w_bit_end) begin
                        // Load the byte here so the data bits shift out LSB first.
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_byte[0];
                        r_shift   <= {1'b0, w_byte[7:1]};
                        r_state   <= DATA_BITS;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                STOP_BIT: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_byte_idx < 3'd5) begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx       <= 1'b0;
                            r_state    <= START_BIT;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
